mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word-address width of the shared memory port.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MEM_LAT, default 1, memory read latency in clk cycles (range 1..7).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports mN_read, mN_write  input  1 each  read and write requests from requester N (N = 0, 1).
REQ-007 SHALL have ports mN_addr  input  ADDR_W, mN_wdata  input  DATA_W, mN_sh  input  1 (save half), mN_lh  input  1 (load half).
REQ-008 SHALL have ports mN_rdata  output  DATA_W, registered read data, and mN_ok  output  1, completion pulse.
REQ-009 SHALL have ports mem_addr  output  ADDR_W, mem_we  output  1, mem_wdata  output  DATA_W, mem_sh  output  1, mem_lh  output  1, all registered.
REQ-010 SHALL have port mem_rdata  input  DATA_W, synchronous memory read data.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE.
REQ-012 IDLE: when either requester has read|write high at edge E0, SHALL latch the winner's addr, wdata, sh, lh and write flag, record the grant, and go to ISSUE.
REQ-013 Arbitration SHALL be round-robin: when both request, grant the requester not granted last; when one requests, grant it; after reset the last-grant pointer = 1, so m0 wins the first tie.
REQ-014 A request with read and write both high SHALL be treated as a write.
REQ-015 ISSUE SHALL last exactly one cycle, driving the latched fields on mem_*; mem_we = 1 only in ISSUE and only for writes.
REQ-016 WAIT SHALL last MEM_LAT cycles; mem_addr, mem_sh and mem_lh SHALL hold their latched values through WAIT.
REQ-017 At edge E0+1+MEM_LAT, SHALL capture mem_rdata into the granted mK_rdata, set mK_ok = 1 and enter DONE; for writes, rdata capture is still performed.
REQ-018 DONE SHALL clear mK_ok at the next edge and return to IDLE; mN_ok SHALL therefore be high for exactly one cycle per transaction.
REQ-019 The non-granted requester's rdata and ok SHALL remain unchanged; both ok outputs SHALL never be high together.
REQ-020 Requests are level-sensitive and SHALL be sampled only in IDLE: a requester still asserting in the IDLE cycle after DONE starts a new transaction, and a request arriving during ISSUE/WAIT/DONE waits without loss.
REQ-021 Each transaction SHALL take MEM_LAT+3 cycles from the IDLE sample to the next IDLE sample, with no back-to-back overlap.
REQ-022 Changes on the granted requester's inputs after E0 SHALL NOT affect the transaction in flight.

Reset
REQ-023 With rst_n low at an edge, SHALL set state = IDLE, last-grant = 1, mN_ok = 0, mN_rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_sh = 0 and mem_lh = 0.
REQ-024 Reset mid-transaction SHALL abort it: mem_we = 0 from the reset edge, no ok pulse is issued, and the first post-reset tie is won by m0.

Structure
REQ-025 The FSM state encoding, ADDR_W/DATA_W defaults and the screen base constant 14'h3000 SHALL live in a shared package used by the memory-side blocks.
REQ-026 The round-robin grant logic SHALL be a sub-module named rr_grant2 (inputs: two requests and the last pointer; outputs: one-hot grant).

Verification
REQ-027 Single read: m0_read with addr 0x0010, memory word 0xDEADBEEF, MEM_LAT = 1 -> m0_ok high one cycle at E0+2, m0_rdata = 0xDEADBEEF, mem_we never high.
REQ-028 Write then read: m1 writes 0x12345678 to 0x3000, then reads it back -> mem_we high for exactly one cycle during the write, and the read returns 0x12345678 on m1_rdata.
REQ-029 Contention: both requesters hold a read continuously for 6 transactions -> grants alternate m0, m1, m0, ..., each transaction spans 4 cycles, and the ok pulses never overlap.
REQ-030 Half access: m0 write with sh = 1 to 0x0004 -> mem_sh = 1 throughout ISSUE and WAIT, and mem_wdata equals m0_wdata.
REQ-031 Reset mid-WAIT: rst_n low during WAIT of an m1 read -> no m1_ok pulse, all outputs zero, and the next simultaneous request grants m0.
REQ-032 Read+write both high on m1 -> treated as a write, with mem_we = 1 in ISSUE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the memory-side blocks.
// Provides the arbiter FSM state encoding, default port widths and the screen base address.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 32;
    localparam logic [13:0] SCREEN_BASE = 14'h3000;
endpackage

// File: rtl/rr_grant2.sv
// rr_grant2: two-way round-robin grant.
// Ports: req0/req1 requests, last = index granted most recently, grant one-hot result.
module rr_grant2
    import mem_port_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] grant
);
    // on a tie the requester that did not win last time gets the port
    assign grant[0] = req0 & (~req1 | last);
    assign grant[1] = req1 & (~req0 | ~last);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between two requesters.
// Ports: clk, rst_n (sync, active low); per requester mN_read/write/addr/wdata/sh/lh in,
// mN_rdata/mN_ok out; registered mem_addr/we/wdata/sh/lh out, mem_rdata in.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_sh,
    input  logic              m0_lh,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ok,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_sh,
    input  logic              m1_lh,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ok,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_sh,
    output logic              mem_lh,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t state, state_nx;
    logic [1:0] grant;
    logic [2:0] cnt;
    logic last, gnt, start, wait_done;
    rr_grant2 u_rr (
        .req0  (m0_read | m0_write),
        .req1  (m1_read | m1_write),
        .last  (last),
        .grant (grant)
    );
    assign start     = (state == IDLE) && (|grant);
    assign wait_done = (state == WAIT) && (cnt == 3'(MEM_LAT - 1));
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = wait_done ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    // the mem_* registers double as the latched request: loaded once at the
    // IDLE sample and left alone until the next grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last      <= 1'b1;
            gnt       <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_sh    <= 1'b0;
            mem_lh    <= 1'b0;
            mem_we    <= 1'b0;
            m0_ok     <= 1'b0;
            m1_ok     <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            mem_we <= 1'b0;
            m0_ok  <= 1'b0;
            m1_ok  <= 1'b0;
            cnt    <= (state == WAIT) ? cnt + 3'd1 : 3'd0;
            if (start) begin
                gnt       <= grant[1];
                last      <= grant[1];
                mem_addr  <= grant[1] ? m1_addr  : m0_addr;
                mem_wdata <= grant[1] ? m1_wdata : m0_wdata;
                mem_sh    <= grant[1] ? m1_sh    : m0_sh;
                mem_lh    <= grant[1] ? m1_lh    : m0_lh;
                mem_we    <= grant[1] ? m1_write : m0_write;
            end
            if (wait_done && gnt) begin
                m1_rdata <= mem_rdata;
                m1_ok    <= 1'b1;
            end
            if (wait_done && !gnt) begin
                m0_rdata <= mem_rdata;
                m0_ok    <= 1'b1;
            end
        end
    end
endmodule
